mux_rr_scheduler: RTL and testbench
===================================

// Module: mux_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 1-bit output channel among 16 requesters.
//  Drives the select of an internal mux_16x1 and grants one requester at a time for a burst of beats.
//  Presents the selected bit downstream with a valid/ready handshake.
//  Sits between 16 serial bit sources and a single serial consumer.
// PARAMETERS
//  N_REQ   16  number of requesters; fixed at 16 to match mux_16x1
//  SEL_W   4   select width, log2(N_REQ)
//  BURST_W 4   width of burst_len and the beat counter
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  req        in   16       per-requester request, level
//  din        in   16       per-requester data bit; din[k] belongs to requester k
//  burst_len  in   BURST_W  beats per grant; sampled at grant; 0 treated as 1
//  out_ready  in   1        consumer ready
//  out_valid  out  1        beat valid
//  out_data   out  1        din[out_src], via mux_16x1
//  out_src    out  SEL_W    index of the granted requester (mux select)
//  grant      out  16       one-hot grant; all zero when idle
//  busy       out  1        high whenever state is XFER
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, out_valid=0, grant=0, out_src=0, busy=0, beat_cnt=0, last_ptr=15.
//  With last_ptr=15 after reset, the first search starts at requester 0.
//  FSM states: IDLE, XFER.
//  IDLE: if |req, pick the winner: the first set bit of req searching last_ptr+1, +2, ... mod 16 (wraps 15->0).
//   On the same edge: out_src<=winner, grant<=1<<winner,
//   beat_cnt<=(burst_len==0 ? 1 : burst_len), state<=XFER.
//   Latency: req sampled at edge n gives grant/out_valid high after edge n.
//  XFER: out_valid=1, busy=1; out_data=din[out_src], combinational through mux_16x1 (no register).
//   Handshake occurs when out_valid && out_ready at the clock edge; beat_cnt decrements by 1.
//   Handshake with beat_cnt==1: last_ptr<=out_src, grant<=0, state<=IDLE.
//   This gives one bubble cycle in IDLE before the next grant.
//   out_ready=0: out_valid, out_src, grant, beat_cnt and out_data selection all held; valid never drops without a handshake.
//  req changes during XFER are ignored; the burst always completes all beats.
//   The granted source must keep din valid until its grant drops.
//  burst_len changes during XFER have no effect until the next grant.
//  Sole requester: the same requester is re-granted after the bubble (search wraps to itself).
//  req==0 in IDLE: stay in IDLE; last_ptr unchanged.
//  Reset mid-burst: burst aborted, outputs cleared at once, round-robin history lost (last_ptr=15).
//  Width rules: beat_cnt is BURST_W bits, so the maximum burst is 2^BURST_W-1 beats.
//   Pointer arithmetic is mod 16 on SEL_W bits.
// STRUCTURE
//  Shared package mux_sched_pkg: N_REQ, SEL_W, BURST_W, state encodings ST_IDLE=1'b0, ST_XFER=1'b1.
//  Sub-module: existing mux_16x1 (i=din, s=out_src, y=out_data); instantiate as-is.
//  Winner search: a combinational rotate-priority function (rotate req right by last_ptr+1,
//   priority-encode, add offset back mod 16); no further sub-modules.
// TESTING
//  1 req=0x0008, burst_len=2, ready=1: grant=0x0008, out_src=3 one cycle after req;
//    exactly 2 valid beats, out_data tracks din[3]; then 1 IDLE cycle.
//  2 req=0xFFFF, burst_len=1, ready=1: out_src sequence 0,1,...,15,0 (wrap).
//    Each grant lasts 1 beat plus 1 bubble.
//  3 During XFER hold out_ready=0 for 5 cycles: out_valid=1 and out_src/grant unchanged;
//    toggling din[out_src] shows on out_data; beat count resumes when ready=1.
//  4 Grant 5, then req=0x0021: next grants are 0, then 5 (search starts at 6 and wraps).
//    req=0x0000 leaves the block idle, grant=0.
//  5 burst_len=0 -> exactly 1 beat. burst_len=15 -> 15 beats.
//    Changing burst_len mid-burst does not alter the current count.
//  6 Assert rst mid-burst (beat 2 of 4) with clk stopped: out_valid/grant/busy go to 0 immediately.
//    After release with req=0x8001: first grant is requester 0.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin 1-bit channel scheduler.
//   N_REQ   : number of requesters (fixed at 16 to match mux_16x1)
//   SEL_W   : select width, log2(N_REQ)
//   BURST_W : width of burst_len and the beat counter
//   state_t : scheduler FSM states
//   rr_pick : rotate-priority winner search
package mux_sched_pkg;

  localparam int unsigned N_REQ   = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned BURST_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Winner search starting just after last: rotate req right by last+1,
  // take the lowest set bit, then add the offset back (mod N_REQ on SEL_W bits).
  // Only meaningful when |req; returns last+1 otherwise.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0]   off;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   pos;
    off = last + 1'b1;
    dbl = {req, req};
    rot = dbl[off +: N_REQ];
    pos = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[N_REQ-1-i]) pos = SEL_W'(N_REQ-1-i);
    end
    return pos + off;
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// 16-to-1 single-bit multiplexer.
//   i : 16 data inputs
//   s : 4-bit select
//   y : i[s]
module mux_16x1 (
  input  logic [15:0] i,
  input  logic [3:0]  s,
  output logic        y
);

  always_comb begin
    y = i[s];
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 1-bit output channel among 16 requesters.
// Grants one requester at a time for a burst of beats; the granted bit is
// presented downstream through mux_16x1 with a valid/ready handshake.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   req       : per-requester level request
//   din       : per-requester data bit
//   burst_len : beats per grant, sampled at grant (0 means 1)
//   out_ready : consumer ready
//   out_valid : beat valid
//   out_data  : din[out_src], combinational
//   out_src   : granted requester index
//   grant     : one-hot grant, zero when idle
//   busy      : high while transferring
module mux_rr_scheduler
  import mux_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   din,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t             r_state;
  logic               r_valid;
  logic               r_busy;
  logic [SEL_W-1:0]   r_src;
  logic [SEL_W-1:0]   r_last;
  logic [N_REQ-1:0]   r_grant;
  logic [BURST_W-1:0] r_beat;
  logic [SEL_W-1:0]   w_winner;
  logic               w_data;

  always_comb begin
    w_winner = rr_pick(req, r_last);
  end

  mux_16x1 u_mux (
    .i (din),
    .s (r_src),
    .y (w_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_src   <= '0;
      r_last  <= '1;
      r_grant <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_src   <= w_winner;
            r_grant <= ONE_HOT0 << w_winner;
            r_beat  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (r_valid && out_ready) begin
            r_beat <= r_beat - 1'b1;
            if (r_beat == BURST_W'(1)) begin
              r_last  <= r_src;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = w_data;
  assign out_src   = r_src;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: stimulus pushes expected beat
// sources, a negedge monitor pops and checks every handshake beat.
module tb_mux_rr_scheduler;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] din = 16'hA5C3;
  logic [3:0]  burst_len = 4'd1;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic        out_data;
  logic [3:0]  out_src;
  logic [15:0] grant;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  mux_rr_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .burst_len (burst_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .grant     (grant),
    .busy      (busy)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat transfers on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_src", 32'(out_src), 32'hFFFF);
      end else begin
        logic [3:0]  e;
        logic [15:0] oh;
        e  = exp_q.pop_front();
        oh = 16'd1 << e;
        chk("beat_src",   32'(out_src),  32'(e));
        chk("beat_grant", 32'(grant),    32'(oh));
        chk("beat_data",  32'(out_data), 32'(din[e]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [3:0] src, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(src);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_grant"}, 32'(grant),     32'd0);
    chk({name, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset_src", 32'(out_src), 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk_idle("por");
    step();
    rst = 1'b0;

    // 1: single requester 3, 2 beats, bubble, re-grant of the sole requester
    din = 16'hA5CB;
    burst_len = 4'd2;
    push_n(4'd3, 4);
    req = 16'h0008;
    step();
    chk("t1_grant", 32'(grant), 32'h0008);
    chk("t1_src",   32'(out_src), 32'd3);
    chk("t1_busy",  32'(busy), 32'd1);
    step();
    chk("t1_valid_beat2", 32'(out_valid), 32'd1);
    step();
    chk_idle("t1_bubble");
    step();
    chk("t1_regrant", 32'(grant), 32'h0008);
    req = '0;
    wait_drain("t1_drain", 20);
    step();
    chk_idle("t1_end");

    // 2: all requesting, 1 beat each, full rotation with wrap
    do_reset();
    burst_len = 4'd1;
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    exp_q.push_back(4'd0);
    req = 16'hFFFF;
    wait_drain("t2_drain", 40);
    req = '0;
    step();
    chk_idle("t2_end");

    // 3: backpressure holds everything; data tracks din[src] combinationally
    burst_len = 4'd3;
    push_n(4'd2, 3);
    req = 16'h0004;
    step();
    out_ready = 1'b0;
    req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_src",   32'(out_src),   32'd2);
      chk("t3_hold_grant", 32'(grant),     32'h0004);
      din[2] = ~din[2];
      #1;
      chk("t3_data_track", 32'(out_data), 32'(din[2]));
    end
    out_ready = 1'b1;
    wait_drain("t3_drain", 20);
    step();
    chk_idle("t3_end");

    // 4: grant 5, then req 0x0021 -> 0 (wrap), then 5
    do_reset();
    burst_len = 4'd1;
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd5);
    req = 16'h0020;
    step();
    chk("t4_grant5", 32'(grant), 32'h0020);
    req = 16'h0021;
    wait_drain("t4_drain", 20);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("t4_noreq");
    end

    // 5: burst_len 0 -> 1 beat; burst_len 15 -> 15 beats despite mid-burst change
    burst_len = 4'd0;
    push_n(4'd8, 1);
    req = 16'h0100;
    step();
    chk("t5_grant8", 32'(grant), 32'h0100);
    req = '0;
    wait_drain("t5a_drain", 10);
    step();
    chk_idle("t5a_end");
    burst_len = 4'd15;
    push_n(4'd1, 15);
    req = 16'h0002;
    step();
    req = '0;
    burst_len = 4'd3;
    wait_drain("t5b_drain", 40);
    step();
    chk_idle("t5b_end");

    // 6: async reset mid-burst with clock stopped
    burst_len = 4'd4;
    push_n(4'd4, 4);
    req = 16'h0010;
    step();
    chk("t6_grant4", 32'(grant), 32'h0010);
    req = '0;
    step();
    chk("t6_midburst", 32'(out_valid), 32'd1);
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_idle("t6_async_rst");
    chk("t6_rst_src", 32'(out_src), 32'd0);
    exp_q.delete();
    req = 16'h8001;
    burst_len = 4'd1;
    exp_q.push_back(4'd0);
    #10;
    rst = 1'b0;
    #1;
    clk_en = 1'b1;
    step();
    chk("t6_first_grant", 32'(grant), 32'h0001);
    req = '0;
    wait_drain("t6_drain", 10);
    step();
    chk_idle("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
